// File: rtl/kcpsmx_stack_ctrl.sv
// Call/return stack controller for a zero-latency-read stack RAM; owns sp, count and error flags.
// Build option: KCPSMX_STACK_OVF_TRAP_EN suppresses pushes into a full stack instead of overwriting the oldest entry.
module kcpsmx_stack_ctrl #(
    parameter int STACK_DEPTH = 5,
    parameter int STACK_WIDTH = 10,
    parameter int STACK_SIZE  = 31
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [STACK_WIDTH-1:0] push_data_i,
    output logic [STACK_WIDTH-1:0] return_address_o,
    output logic [STACK_DEPTH-1:0] stack_address_o,
    output logic                   stack_we_o,
    output logic [STACK_WIDTH-1:0] stack_wdata_o,
    input  logic [STACK_WIDTH-1:0] stack_rdata_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam logic [STACK_DEPTH-1:0] SP_LAST = STACK_DEPTH'(STACK_SIZE - 1);
    localparam logic [STACK_DEPTH-1:0] SP_ONE  = STACK_DEPTH'(1);
    localparam logic [STACK_DEPTH:0]   CNT_MAX = (STACK_DEPTH + 1)'(STACK_SIZE);
    localparam logic [STACK_DEPTH:0]   CNT_ONE = (STACK_DEPTH + 1)'(1);

    logic [STACK_DEPTH-1:0] sp_q, sp_d, sp_inc, sp_dec;
    logic [STACK_DEPTH:0]   count_q, count_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;

    assign full_o           = (count_q == CNT_MAX);
    assign empty_o          = (count_q == '0);
    assign overflow_o       = ovf_q;
    assign underflow_o      = unf_q;
    assign return_address_o = stack_rdata_i;
    assign stack_wdata_o    = push_data_i;

    // Pointer arithmetic wraps modulo STACK_SIZE, which need not be a power of two.
    assign sp_inc = (sp_q == SP_LAST) ? '0 : sp_q + SP_ONE;
    assign sp_dec = (sp_q == '0) ? SP_LAST : sp_q - SP_ONE;

    always_comb begin
        sp_d            = sp_q;
        count_d         = count_q;
        ovf_d           = ovf_q;
        unf_d           = unf_q;
        stack_address_o = sp_dec;
        stack_we_o      = 1'b0;

        if (push_i && pop_i && !empty_o) begin
            // Replace top: the RAM read of the old top completes before the write lands.
            stack_we_o = 1'b1;
        end else begin
            if (pop_i && empty_o) begin
                unf_d = 1'b1;
            end
            if (push_i) begin
                stack_address_o = sp_q;
                if (full_o) begin
                    ovf_d = 1'b1;
`ifdef KCPSMX_STACK_OVF_TRAP_EN
                    stack_we_o = 1'b0;
`else
                    stack_we_o = 1'b1;
                    sp_d       = sp_inc;
`endif
                end else begin
                    stack_we_o = 1'b1;
                    sp_d       = sp_inc;
                    count_d    = count_q + CNT_ONE;
                end
            end else if (pop_i && !empty_o) begin
                sp_d    = sp_dec;
                count_d = count_q - CNT_ONE;
            end
        end

        if (reset_i) begin
            stack_we_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: tb/tb_kcpsmx_stack_ctrl.sv
// Bench for kcpsmx_stack_ctrl with a behavioural stack RAM and a queue-based stack model.
module tb_kcpsmx_stack_ctrl;

`ifdef KCPSMX_STACK_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int SIZE = 31;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [9:0] push_data = '0;
    logic [9:0] return_address;
    logic [4:0] stack_address;
    logic       stack_we;
    logic [9:0] stack_wdata;
    logic [9:0] stack_rdata;
    logic       full, empty, overflow, underflow;

    logic [9:0] mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) if (stack_we) mem[stack_address] <= stack_wdata;
    assign stack_rdata = mem[stack_address];

    kcpsmx_stack_ctrl dut (
        .clk_i(clk), .reset_i(reset), .push_i(push), .pop_i(pop),
        .push_data_i(push_data), .return_address_o(return_address),
        .stack_address_o(stack_address), .stack_we_o(stack_we),
        .stack_wdata_o(stack_wdata), .stack_rdata_i(stack_rdata),
        .full_o(full), .empty_o(empty), .overflow_o(overflow), .underflow_o(underflow)
    );

    typedef struct {
        bit         pu;
        bit         po;
        logic [9:0] d;
        bit         chk_ret;
        logic [9:0] ret;
        bit         e_empty;
        bit         e_full;
        bit         e_ovf;
        bit         e_unf;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;
    logic [9:0] model[$];
    logic [9:0] ret_q[$];
    bit m_ovf = 0, m_unf = 0;
    logic [9:0] last_ret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset(input bit with_push);
        reset = 1'b1; push = with_push; pop = 1'b0; push_data = 10'h155;
        #1;
        if (with_push) chk("we_during_reset", {31'd0, stack_we}, 32'd0);
        @(posedge clk); #1;
        push = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model.delete(); ret_q.delete(); m_ovf = 0; m_unf = 0;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_unf", {31'd0, underflow}, 32'd0);
        chk("rst_we", {31'd0, stack_we}, 32'd0);
    endtask

    // Drive one cycle; scoreboard predicts RAM write enable, popped value and flags.
    task automatic step(input bit pu, input bit po, input logic [9:0] d);
        bit exp_we;
        int sz;
        sz = model.size();
        push = pu; pop = po; push_data = d;
        exp_we = pu && !(TRAP && sz == SIZE);
        if (po && sz > 0) ret_q.push_back(model[$]);
        #1;
        chk("stack_we", {31'd0, stack_we}, {31'd0, exp_we});
        last_ret = return_address;
        if (ret_q.size() > 0) chk("return_address", {22'd0, return_address}, {22'd0, ret_q.pop_front()});
        @(posedge clk); #1;
        if (pu && po && sz > 0) begin
            model[$] = d;
        end else begin
            if (po && sz == 0) m_unf = 1;
            if (po && !pu && sz > 0) void'(model.pop_back());
            if (pu) begin
                if (sz == SIZE) begin
                    m_ovf = 1;
                    if (!TRAP) begin
                        void'(model.pop_front());
                        model.push_back(d);
                    end
                end else begin
                    model.push_back(d);
                end
            end
        end
        push = 1'b0; pop = 1'b0;
        chk("empty", {31'd0, empty}, {31'd0, model.size() == 0});
        chk("full", {31'd0, full}, {31'd0, model.size() == SIZE});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 0, 10'h123, 0, 10'h000, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 10'h045, 0, 10'h000, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 10'h000, 1, 10'h045, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 10'h000, 1, 10'h123, 1, 0, 0, 0};
        tbl[4] = '{1, 0, 10'h020, 0, 10'h000, 0, 0, 0, 0};
        tbl[5] = '{1, 0, 10'h010, 0, 10'h000, 0, 0, 0, 0};
        tbl[6] = '{1, 1, 10'h3FF, 1, 10'h010, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 10'h000, 1, 10'h3FF, 0, 0, 0, 0};
        tbl[8] = '{0, 1, 10'h000, 1, 10'h020, 1, 0, 0, 0};

        @(posedge clk); #1;
        do_reset(1'b1);
        repeat (2) step(0, 0, '0);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].pu, tbl[i].po, tbl[i].d);
            if (tbl[i].chk_ret) chk($sformatf("tbl%0d_ret", i), {22'd0, last_ret}, {22'd0, tbl[i].ret});
            chk($sformatf("tbl%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
            chk($sformatf("tbl%0d_full", i), {31'd0, full}, {31'd0, tbl[i].e_full});
            chk($sformatf("tbl%0d_flags", i), {30'd0, overflow, underflow}, {30'd0, tbl[i].e_ovf, tbl[i].e_unf});
        end

        // Fill to capacity, then drain through the sp wrap at index 0.
        do_reset(1'b0);
        for (int i = 1; i <= SIZE; i++) step(1, 0, 10'(i));
        chk("full_after_31", {31'd0, full}, 32'd1);
        for (int i = SIZE; i >= 1; i--) begin
            step(0, 1, '0);
            chk("drain_order", {22'd0, last_ret}, i);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Underflow is sticky until reset.
        step(0, 1, '0);
        for (int i = 0; i < 10; i++) step(0, 0, '0);
        chk("unf_sticky", {31'd0, underflow}, 32'd1);
        step(1, 1, 10'h077);
        chk("pushpop_empty_pushes", {31'd0, empty}, 32'd0);
        do_reset(1'b0);

        // Push into a full stack.
        for (int i = 1; i <= SIZE; i++) step(1, 0, 10'(i));
        step(1, 0, 10'h2AA);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        step(0, 1, '0);
        chk("first_pop_after_ovf", {22'd0, last_ret}, TRAP ? 32'd31 : 32'h2AA);
        for (int i = 1; i < SIZE; i++) step(0, 1, '0);
        chk("ovf_after_drain", {31'd0, overflow}, 32'd1);
        chk("empty_after_drain", {31'd0, empty}, 32'd1);
        do_reset(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
